// File: rtl/q_weight_sequencer.sv
// Weight-table access sequencer for a spline adaptive filter: one filter read per sample,
// then an optional read-modify-write of the span's weights once the error term arrives.
module q_weight_sequencer #(
    parameter int Q       = 13,
    parameter int Q_ORD   = 4,
    parameter int TIMEOUT = 64,
    parameter int IW      = $clog2(Q + Q_ORD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [IW-1:0] in_span,
    output logic          in_ready,
    input  logic          adapt_en,
    input  logic          err_valid,
    output logic          err_ready,
    output logic [IW-1:0] span_ind_read,
    output logic          rd_valid,
    output logic [IW-1:0] span_ind_write,
    output logic          upd_rd_valid,
    output logic [IW-1:0] span_ind_write_d,
    output logic          wr_en,
    output logic          range_err,
    output logic          timeout,
    output logic [15:0]   sample_cnt
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] Q_IDX    = IW'(Q);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD, WAIT_ERR, UPD_RD, UPD_WR} state_t;

    state_t        state;
    logic [IW-1:0] span_q;
    logic          adapt_q;
    logic [WW-1:0] wait_cnt;
    logic [IW-1:0] span_clamped;
    logic          span_over;

    // Out-of-range spans are pinned to Q so the weight window never runs off the table.
    always_comb begin
        span_over    = (in_span > Q_IDX);
        span_clamped = span_over ? Q_IDX : in_span;
    end

    assign err_ready = (state == WAIT_ERR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            span_q           <= '0;
            adapt_q          <= 1'b0;
            wait_cnt         <= '0;
            in_ready         <= 1'b1;
            span_ind_read    <= '0;
            rd_valid         <= 1'b0;
            span_ind_write   <= '0;
            upd_rd_valid     <= 1'b0;
            span_ind_write_d <= '0;
            wr_en            <= 1'b0;
            range_err        <= 1'b0;
            timeout          <= 1'b0;
            sample_cnt       <= '0;
        end else begin
            rd_valid     <= 1'b0;
            upd_rd_valid <= 1'b0;
            wr_en        <= 1'b0;
            range_err    <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        span_q        <= span_clamped;
                        adapt_q       <= adapt_en;
                        range_err     <= span_over;
                        rd_valid      <= 1'b1;
                        span_ind_read <= span_clamped;
                        in_ready      <= 1'b0;
                        state         <= RD;
                    end
                end
                RD: begin
                    if (adapt_q) begin
                        wait_cnt <= '0;
                        state    <= WAIT_ERR;
                    end else begin
                        sample_cnt <= sample_cnt + 16'd1;
                        in_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                WAIT_ERR: begin
                    // An error term arriving on the last allowed cycle still counts.
                    if (err_valid) begin
                        upd_rd_valid   <= 1'b1;
                        span_ind_write <= span_q;
                        state          <= UPD_RD;
                    end else if (wait_cnt == WAIT_MAX) begin
                        timeout  <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                UPD_RD: begin
                    wr_en            <= 1'b1;
                    span_ind_write_d <= span_q;
                    state            <= UPD_WR;
                end
                UPD_WR: begin
                    sample_cnt <= sample_cnt + 16'd1;
                    in_ready   <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_weight_sequencer.sv
// Bench for q_weight_sequencer: directed and random samples against a per-sample
// expectation model of the read / wait / update / write sequence.
module tb_q_weight_sequencer;

    localparam int Q       = 13;
    localparam int Q_ORD   = 4;
    localparam int TIMEOUT = 64;
    localparam int IW      = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [IW-1:0] in_span;
    logic          in_ready;
    logic          adapt_en;
    logic          err_valid;
    logic          err_ready;
    logic [IW-1:0] span_ind_read;
    logic          rd_valid;
    logic [IW-1:0] span_ind_write;
    logic          upd_rd_valid;
    logic [IW-1:0] span_ind_write_d;
    logic          wr_en;
    logic          range_err;
    logic          timeout;
    logic [15:0]   sample_cnt;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [15:0] model_cnt = '0;

    always #5 clk = ~clk;

    q_weight_sequencer #(.Q(Q), .Q_ORD(Q_ORD), .TIMEOUT(TIMEOUT), .IW(IW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_span(in_span),
        .in_ready(in_ready), .adapt_en(adapt_en), .err_valid(err_valid),
        .err_ready(err_ready), .span_ind_read(span_ind_read), .rd_valid(rd_valid),
        .span_ind_write(span_ind_write), .upd_rd_valid(upd_rd_valid),
        .span_ind_write_d(span_ind_write_d), .wr_en(wr_en), .range_err(range_err),
        .timeout(timeout), .sample_cnt(sample_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One sample from IDLE. wait_n = idle WAIT_ERR cycles before err_valid is raised;
    // wait_n >= TIMEOUT means the error term never arrives.
    task automatic run_sample(input int unsigned span, input bit adapt, input int unsigned wait_n);
        logic [IW-1:0] exp_span;
        int unsigned   i;
        exp_span = (span > Q) ? IW'(Q) : IW'(span);
        chk("idle_in_ready", in_ready, 1);
        in_valid = 1'b1; in_span = IW'(span); adapt_en = adapt;
        step();
        in_valid = 1'b0; adapt_en = 1'b0;
        chk("rd_valid", rd_valid, 1);
        chk("span_ind_read", span_ind_read, exp_span);
        chk("range_err", range_err, (span > Q) ? 1 : 0);
        chk("rd_in_ready", in_ready, 0);
        if (!adapt) begin
            step();
            model_cnt++;
            chk("noadapt_in_ready", in_ready, 1);
            chk("noadapt_rd_drop", rd_valid, 0);
            chk("noadapt_no_upd", upd_rd_valid | wr_en, 0);
            chk("read_idx_hold", span_ind_read, exp_span);
            chk("noadapt_cnt", sample_cnt, model_cnt);
            return;
        end
        step();
        for (i = 0; i < TIMEOUT; i++) begin
            chk("wait_err_ready", err_ready, 1);
            chk("wait_no_wr", wr_en | timeout, 0);
            if (i == wait_n) begin
                err_valid = 1'b1;
                step();
                err_valid = 1'b0;
                break;
            end
            step();
        end
        if (wait_n >= TIMEOUT) begin
            chk("timeout_pulse", timeout, 1);
            chk("timeout_in_ready", in_ready, 1);
            chk("timeout_no_wr", wr_en | upd_rd_valid, 0);
            chk("timeout_cnt", sample_cnt, model_cnt);
            step();
            chk("timeout_one_cycle", timeout, 0);
            return;
        end
        chk("upd_rd_valid", upd_rd_valid, 1);
        chk("span_ind_write", span_ind_write, exp_span);
        chk("upd_no_wr", wr_en | timeout | err_ready, 0);
        step();
        chk("wr_en", wr_en, 1);
        chk("span_ind_write_d", span_ind_write_d, exp_span);
        chk("wr_upd_drop", upd_rd_valid, 0);
        step();
        model_cnt++;
        chk("adapt_in_ready", in_ready, 1);
        chk("wr_one_cycle", wr_en, 0);
        chk("adapt_cnt", sample_cnt, model_cnt);
    endtask

    initial begin
        int unsigned rd_cnt, wr_cnt, wt;
        bit          ad;
        reset = 1'b1; in_valid = 1'b0; in_span = '0; adapt_en = 1'b0; err_valid = 1'b0;
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_strobes", {rd_valid, upd_rd_valid, wr_en, range_err, timeout, err_ready}, 0);
        chk("rst_indices", {span_ind_read, span_ind_write, span_ind_write_d}, 0);
        chk("rst_cnt", sample_cnt, 0);
        reset = 1'b0;
        step();

        run_sample(7, 1'b0, 0);
        run_sample(5, 1'b1, 3);
        run_sample(20, 1'b1, 0);
        run_sample(20, 1'b0, 0);
        run_sample(13, 1'b1, 1);
        run_sample(9, 1'b1, TIMEOUT);
        run_sample(3, 1'b1, TIMEOUT - 1);

        for (int n = 0; n < 24; n++) begin
            ad = 1'($urandom_range(0, 1));
            wt = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 6);
            run_sample($urandom_range(0, 31), ad, wt);
        end

        // Reset during UPD_RD aborts the write.
        in_valid = 1'b1; in_span = 5'd11; adapt_en = 1'b1;
        step();
        in_valid = 1'b0; err_valid = 1'b1;
        step();
        step();
        err_valid = 1'b0;
        chk("pre_reset_upd_rd", upd_rd_valid, 1);
        reset = 1'b1;
        step();
        chk("inrst_strobes", {rd_valid, upd_rd_valid, wr_en, range_err, timeout, err_ready}, 0);
        chk("inrst_indices", {span_ind_read, span_ind_write, span_ind_write_d, sample_cnt}, 0);
        chk("inrst_in_ready", in_ready, 1);
        reset = 1'b0;
        model_cnt = '0;
        step();
        chk("postrst_no_wr", wr_en, 0);
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_cnt", sample_cnt, model_cnt);

        // Back-to-back adaptive samples with counter wrap.
        force dut.sample_cnt = 16'hFFFE;
        #1;
        release dut.sample_cnt;
        model_cnt = 16'hFFFE;
        rd_cnt = 0; wr_cnt = 0;
        in_valid = 1'b1; adapt_en = 1'b1; err_valid = 1'b1; in_span = 5'd8;
        for (int c = 1; c <= 40; c++) begin
            if (c == 40) begin
                in_valid = 1'b0; err_valid = 1'b0; adapt_en = 1'b0;
            end
            step();
            if (rd_valid) begin
                rd_cnt++;
                chk("b2b_rd_phase", c % 5, 1);
            end
            if (wr_en) begin
                wr_cnt++;
                chk("b2b_wr_phase", c % 5, 4);
            end
        end
        model_cnt = model_cnt + 16'd8;
        chk("b2b_rd_count", rd_cnt, 8);
        chk("b2b_wr_count", wr_cnt, 8);
        chk("b2b_cnt_wrap", sample_cnt, model_cnt);
        chk("b2b_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/q_weight_sequencer.md
Q_WEIGHT_SEQUENCER -- requirements
Module: q_weight_sequencer

Interface
REQ-001 Parameters SHALL be: Q, default 13, number of spline spans; Q_ORD, default 4, spline order (weights per span); TIMEOUT, default 64, maximum WAIT_ERR cycles; IW = $clog2(Q+Q_ORD), index width (5 at defaults).
REQ-002 clk  input  1  clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  new sample span index offered.
REQ-005 in_span  input  IW  span index of offered sample.
REQ-006 in_ready  output  1  sequencer accepts a sample.
REQ-007 adapt_en  input  1  weight adaptation enable, sampled at acceptance.
REQ-008 err_valid  input  1  error/update term ready from the update datapath.
REQ-009 err_ready  output  1  error term consumed.
REQ-010 span_ind_read  output  IW  filter-output read index to the weight table.
REQ-011 rd_valid  output  1  span_ind_read is valid this cycle.
REQ-012 span_ind_write  output  IW  old-weight read index for update.
REQ-013 upd_rd_valid  output  1  span_ind_write is valid this cycle.
REQ-014 span_ind_write_d  output  IW  write index for the weight update.
REQ-015 wr_en  output  1  weight table write strobe.
REQ-016 range_err  output  1  one-cycle pulse: accepted in_span exceeded Q.
REQ-017 timeout  output  1  one-cycle pulse: WAIT_ERR abandoned.
REQ-018 sample_cnt  output  16  count of completed samples.

Function
REQ-019 FSM states SHALL be IDLE, RD, WAIT_ERR, UPD_RD, UPD_WR; in_ready SHALL be 1 only in IDLE.
REQ-020 Acceptance: in IDLE with in_valid=1, the block SHALL latch span (clamped to Q if in_span>Q, with range_err pulsed in the next cycle) and adapt_en, then enter RD.
REQ-021 RD: rd_valid=1 and span_ind_read=latched span for exactly one cycle; next state WAIT_ERR if the latched adapt_en=1, else IDLE with sample_cnt+1.
REQ-022 WAIT_ERR: err_ready=1 combinationally; on err_valid=1 the next state SHALL be UPD_RD; the wait counter SHALL increment each cycle without err_valid.
REQ-023 When the wait counter reaches TIMEOUT-1 without err_valid, the block SHALL return to IDLE, pulse timeout, issue no write, and leave sample_cnt unchanged.
REQ-024 If err_valid and the timeout condition coincide, err_valid SHALL win (proceed to UPD_RD, no timeout pulse).
REQ-025 UPD_RD: upd_rd_valid=1 and span_ind_write=latched span for one cycle; next state UPD_WR.
REQ-026 UPD_WR: wr_en=1 and span_ind_write_d=latched span (exactly one cycle after span_ind_write); next state IDLE; sample_cnt+1.
REQ-027 Index outputs SHALL hold their last value when their valid/strobe is 0; wr_en SHALL never assert outside UPD_WR.
REQ-028 Minimum sample period SHALL be 2 cycles with adapt_en=0 and 4+N cycles with adapt_en=1, where N = WAIT_ERR cycles.
REQ-029 sample_cnt SHALL wrap from 16'hFFFF to 0.
REQ-030 Span indices emitted SHALL always lie in 0..Q, so that the index+Q_ORD-1 addressing stays within 0..Q+Q_ORD-1.

Reset
REQ-031 While reset=1 the block SHALL enter IDLE. All outputs except in_ready SHALL be 0; in_ready SHALL be 1 after reset.
REQ-032 Reset asserted in any state, including mid-WAIT_ERR or UPD_RD, SHALL abort the sample with no wr_en pulse at or after the reset edge.
REQ-033 The wait counter and latched span SHALL clear on reset.

Verification
REQ-034 Non-adaptive sample: in_span=7, adapt_en=0 -> rd_valid with span_ind_read=7 one cycle after acceptance; no upd_rd_valid or wr_en; sample_cnt=1; in_ready high again 2 cycles after acceptance.
REQ-035 Adaptive sample: in_span=5, err_valid after 3 cycles -> upd_rd_valid with span_ind_write=5, then wr_en with span_ind_write_d=5 on the next cycle; sample_cnt=1.
REQ-036 Range clamp: in_span=20 -> range_err pulse, span_ind_read=13, and span_ind_write_d=13 if adapting.
REQ-037 Timeout: adapt_en=1, err_valid held 0 -> timeout pulses after TIMEOUT cycles in WAIT_ERR, no wr_en, sample_cnt unchanged; err_valid raised on the final cycle -> normal update and no timeout pulse.
REQ-038 Reset asserted during UPD_RD -> no wr_en, all outputs 0, in_ready=1 the cycle after reset is released.
REQ-039 Back-to-back samples with in_valid held high and err_valid=1 -> one sample completes every 5 cycles; sample_cnt wraps correctly when preloaded to 16'hFFFF.
